// File: rtl/i2s_tx_unit_pkg.sv
// -----------------------------------------------------------------------------
// i2s_tx_unit_pkg
//   Shared constants and types for the I2S transmit unit.
//   - I2S_CLK_DIV   : clk cycles per SCK half-period (SCK period = 2*I2S_CLK_DIV)
//   - I2S_SLOT_BITS : SCK bits per channel slot (frame = 2 slots)
//   - I2S_DATA_BITS : sample width, MSB-first, left-justified in its slot
//   - i2s_state_t   : transmit sequencing states
// -----------------------------------------------------------------------------
package i2s_tx_unit_pkg;

  localparam int I2S_CLK_DIV   = 4;
  localparam int I2S_SLOT_BITS = 32;
  localparam int I2S_DATA_BITS = 24;

  // IDLE  : nothing on the bus, waiting for play mode
  // PRIME : first sample requested, waiting for it to arrive
  // RUN   : streaming frames back to back
  // DRAIN : play dropped, finishing the frame already on the wire
  typedef enum logic [1:0] {
    I2S_IDLE,
    I2S_PRIME,
    I2S_RUN,
    I2S_DRAIN
  } i2s_state_t;

endpackage

// File: rtl/i2s_tx_unit_sck_gen.sv
// -----------------------------------------------------------------------------
// i2s_tx_unit_sck_gen
//   Serial clock generator for the I2S transmitter. While enabled, a divider
//   counts 0..CLK_DIV-1 and SCK toggles on the terminal count. While disabled
//   the divider is held at 0 and SCK is held low, so the first rising edge
//   always comes exactly CLK_DIV clk cycles after enable goes high.
//
// Ports
//   clk        in   system clock
//   rst        in   synchronous active-high reset
//   en_i       in   run the divider (transmitter is streaming)
//   sck_o      out  registered serial clock
//   sck_fall_o out  strobe: SCK goes high->low at the next clk edge
// -----------------------------------------------------------------------------
module i2s_tx_unit_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic sck_o,
  output logic sck_fall_o
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             sck_q, sck_d;
  logic             half_done;

  assign half_done = en_i && (div_cnt_q == DIV_LAST);

  always_comb begin
    // NOTE: every signal written here gets a value before any branch, so no
    // path leaves it unassigned and no latch is inferred.
    div_cnt_d = div_cnt_q;
    sck_d     = sck_q;
    if (!en_i) begin
      div_cnt_d = '0;
      sck_d     = 1'b0;
    end else if (half_done) begin
      div_cnt_d = '0;
      sck_d     = ~sck_q;
    end else begin
      div_cnt_d = div_cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // its next value from the same pre-edge snapshot.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt_q <= '0;
      sck_q     <= 1'b0;
    end else begin
      div_cnt_q <= div_cnt_d;
      sck_q     <= sck_d;
    end
  end

  assign sck_o      = sck_q;
  assign sck_fall_o = half_done && sck_q;

endmodule

// File: rtl/i2s_tx_unit.sv
// -----------------------------------------------------------------------------
// i2s_tx_unit
//   Serialises stereo samples into a Philips I2S stream (SCK, WS, SDO) in the
//   clk domain. A one-entry holding buffer decouples sample delivery (tick_in)
//   from the frame boundary; an empty buffer at a boundary sends a silent frame
//   and pulses underrun_out. req_out pulses once per frame to pull the next
//   sample from the upstream control unit.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   play_in      in   play mode from the control unit
//   tick_in      in   one-cycle strobe: audio0_in/audio1_in valid
//   audio0_in    in   left sample, two's complement
//   audio1_in    in   right sample, two's complement
//   req_out      out  one-cycle sample request
//   sck_out      out  I2S serial clock
//   ws_out       out  I2S word select (0 = left, 1 = right)
//   sdo_out      out  I2S serial data
//   underrun_out out  one-cycle pulse: frame started with empty holding buffer
// -----------------------------------------------------------------------------
module i2s_tx_unit
  import i2s_tx_unit_pkg::*;
#(
  parameter int CLK_DIV   = I2S_CLK_DIV,
  parameter int SLOT_BITS = I2S_SLOT_BITS,
  parameter int DATA_BITS = I2S_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 play_in,
  input  logic                 tick_in,
  input  logic [DATA_BITS-1:0] audio0_in,
  input  logic [DATA_BITS-1:0] audio1_in,
  output logic                 req_out,
  output logic                 sck_out,
  output logic                 ws_out,
  output logic                 sdo_out,
  output logic                 underrun_out
);

  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam int WORD_W     = 2 * DATA_BITS;

  // Bit positions inside a frame (bit_cnt counts SCK falling edges).
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
  localparam logic [CNT_W-1:0] WS_FIRST = CNT_W'(SLOT_BITS - 1);
  localparam logic [CNT_W-1:0] WS_LAST  = CNT_W'(FRAME_BITS - 2);
  localparam logic [CNT_W-1:0] L_END    = CNT_W'(DATA_BITS);
  localparam logic [CNT_W-1:0] R_FIRST  = CNT_W'(SLOT_BITS);
  localparam logic [CNT_W-1:0] R_END    = CNT_W'(SLOT_BITS + DATA_BITS);

  i2s_state_t        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              hold_valid_q, hold_valid_d;
  logic              sdo_q, sdo_d;
  logic              ws_q, ws_d;
  logic              req_q, req_d;
  logic              underrun_q, underrun_d;

  logic              sck_en;
  logic              sck;
  logic              sck_fall;
  logic              frame_end;
  logic              keep_running;
  logic [CNT_W-1:0]  bit_next;
  logic [WORD_W-1:0] tick_word;
  logic [WORD_W-1:0] boundary_word;

  // ---------------------------------------------------------------------------
  // Serial clock
  // ---------------------------------------------------------------------------
  assign sck_en = (state_q == I2S_RUN) || (state_q == I2S_DRAIN);

  i2s_tx_unit_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk        (clk),
    .rst        (rst),
    .en_i       (sck_en),
    .sck_o      (sck),
    .sck_fall_o (sck_fall)
  );

  // The falling edge that wraps bit_cnt back to 0 starts a new frame.
  assign frame_end = sck_fall && (bit_cnt_q == LAST_BIT);
  assign bit_next  = (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + 1'b1;

  // In DRAIN a re-asserted play_in resumes streaming without a gap, so the
  // boundary is treated as a normal RUN boundary.
  assign keep_running = (state_q == I2S_RUN) || play_in;

  assign tick_word     = {audio0_in, audio1_in};
  assign boundary_word = hold_valid_q ? hold_q : '0;

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= I2S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      I2S_IDLE: begin
        if (play_in) state_d = I2S_PRIME;
      end
      I2S_PRIME: begin
        if (!play_in)     state_d = I2S_IDLE;
        else if (tick_in) state_d = I2S_RUN;
      end
      I2S_RUN: begin
        if (!play_in) state_d = I2S_DRAIN;
      end
      I2S_DRAIN: begin
        if (play_in)        state_d = I2S_RUN;
        else if (frame_end) state_d = I2S_IDLE;
      end
      default: state_d = I2S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs and datapath next values
  // ---------------------------------------------------------------------------
  always_comb begin
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    hold_d       = hold_q;
    hold_valid_d = hold_valid_q;
    sdo_d        = sdo_q;
    ws_d         = ws_q;
    req_d        = 1'b0;
    underrun_d   = 1'b0;

    unique case (state_q)
      I2S_IDLE: begin
        bit_cnt_d = '0;
        sdo_d     = 1'b0;
        ws_d      = 1'b0;
        if (play_in) req_d = 1'b1;
      end

      I2S_PRIME: begin
        if (!play_in) begin
          hold_d       = '0;
          hold_valid_d = 1'b0;
        end else if (tick_in) begin
          // First frame goes straight from the input: bit 0 is driven now,
          // before the first SCK rise.
          bit_cnt_d    = '0;
          sdo_d        = tick_word[WORD_W-1];
          shift_d      = {tick_word[WORD_W-2:0], 1'b0};
          ws_d         = 1'b0;
          hold_valid_d = 1'b0;
        end
      end

      I2S_RUN, I2S_DRAIN: begin
        if (sck_fall) begin
          bit_cnt_d = bit_next;
          ws_d      = (bit_next >= WS_FIRST) && (bit_next <= WS_LAST);
          if (frame_end) begin
            if (keep_running) begin
              // Uses the buffer as it was before this edge; a tick on the
              // same cycle lands in hold for the following frame.
              sdo_d        = boundary_word[WORD_W-1];
              shift_d      = {boundary_word[WORD_W-2:0], 1'b0};
              hold_valid_d = 1'b0;
              req_d        = 1'b1;
              underrun_d   = ~hold_valid_q;
            end else begin
              bit_cnt_d = '0;
              sdo_d     = 1'b0;
              ws_d      = 1'b0;
              shift_d   = '0;
            end
          end else if ((bit_next < L_END) ||
                       ((bit_next >= R_FIRST) && (bit_next < R_END))) begin
            sdo_d   = shift_q[WORD_W-1];
            shift_d = {shift_q[WORD_W-2:0], 1'b0};
          end else begin
            sdo_d = 1'b0;
          end
        end
      end

      default: ;
    endcase

    // Newest sample always wins. PRIME consumes the tick directly instead.
    if (tick_in && (state_q != I2S_PRIME)) begin
      hold_d       = tick_word;
      hold_valid_d = 1'b1;
    end
  end

  // NOTE: the holding buffer and shift register are reset along with the
  // control flops so a fresh start can never replay stale audio.
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_valid_q <= 1'b0;
      sdo_q        <= 1'b0;
      ws_q         <= 1'b0;
      req_q        <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      hold_q       <= hold_d;
      hold_valid_q <= hold_valid_d;
      sdo_q        <= sdo_d;
      ws_q         <= ws_d;
      req_q        <= req_d;
      underrun_q   <= underrun_d;
    end
  end

  assign req_out      = req_q;
  assign sck_out      = sck;
  assign ws_out       = ws_q;
  assign sdo_out      = sdo_q;
  assign underrun_out = underrun_q;

endmodule
